// File: rtl/tx_stream_ctrl_pkg.sv
// Shared types, codes and frame-size helper for the S/PDIF stream/config sequencer.
package tx_stream_ctrl_pkg;

    localparam logic [1:0] BIT_DEPTH_16  = 2'b00;
    localparam logic [1:0] BIT_DEPTH_24  = 2'b01;
    localparam logic [1:0] BIT_DEPTH_32  = 2'b10;
    localparam logic [1:0] BIT_DEPTH_DOP = 2'b11;

    localparam logic CHANNELS_MONO   = 1'b0;
    localparam logic CHANNELS_STEREO = 1'b1;

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned RATE_W = 3;
    localparam int unsigned DEPTH_W = 2;

    typedef enum logic [1:0] {
        ST_RUN    = 2'b00,
        ST_DRAIN  = 2'b01,
        ST_APPLY  = 2'b10,
        ST_SETTLE = 2'b11
    } state_t;

    typedef struct packed {
        logic [RATE_W-1:0]  sample_rate;
        logic [DEPTH_W-1:0] bit_depth;
        logic               channels;
    } cfg_t;

    // Bytes in one sample frame: bytes per sample, doubled for stereo.
    function automatic logic [CNT_W-1:0] frame_bytes(input logic [DEPTH_W-1:0] bit_depth,
                                                     input logic channels);
        logic [CNT_W-1:0] bps;
        case (bit_depth)
            BIT_DEPTH_16: bps = CNT_W'(2);
            BIT_DEPTH_24: bps = CNT_W'(3);
            default:      bps = CNT_W'(4);
        endcase
        return channels ? CNT_W'(bps << 1) : bps;
    endfunction

endpackage

// File: rtl/tx_stream_ctrl_sync_ff.sv
// Two-stage synchronizer for a single asynchronous level.
module sync_ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic d_i,
    output logic q_o
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= d_i;
            r_sync <= r_meta;
        end
    end

    assign q_o = r_sync;

endmodule

// File: rtl/tx_stream_ctrl.sv
// Stream forwarder and frame-aligned configuration sequencer in front of the S/PDIF FIFO.
// Optional request validation (rejects 32-bit/DoP depths) is built when CFG_VALIDATE_EN is defined.
module tx_stream_ctrl
    import tx_stream_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CLOCKS = 64,
    parameter int unsigned DRAIN_GUARD   = 16
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               cfg_req_i,
    input  logic [RATE_W-1:0]  cfg_sample_rate_i,
    input  logic [DEPTH_W-1:0] cfg_bit_depth_i,
    input  logic               cfg_channels_i,
    output logic               cfg_ack_o,
    output logic               cfg_err_o,
    output logic               busy_o,
    input  logic [DATA_W-1:0]  s_data_i,
    input  logic               s_valid_i,
    output logic               s_ready_o,
    output logic               wr_en_o,
    output logic [DATA_W-1:0]  wr_data_o,
    input  logic               wr_afull_i,
    input  logic               wr_full_i,
    input  logic               streaming_i,
    output logic [RATE_W-1:0]  sample_rate_o,
    output logic [DEPTH_W-1:0] bit_depth_o,
    output logic               channels_o
);

    // Guard also spans the synchronizer depth so the flag seen is newer than the guard window.
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned GUARD_LIMIT = DRAIN_GUARD + SYNC_STAGES;
    localparam int unsigned GUARD_W     = $clog2(GUARD_LIMIT + 1);
    localparam int unsigned SETTLE_W    = (SETTLE_CLOCKS > 1) ? $clog2(SETTLE_CLOCKS) : 1;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_pending;
    cfg_t                  r_req;
    cfg_t                  r_cfg;
    logic [GUARD_W-1:0]    r_guard;
    logic [SETTLE_W-1:0]   r_settle;
    logic                  r_wr_en;
    logic [DATA_W-1:0]     r_wr_data;
    logic                  r_ack;
    logic                  r_err;

    logic                  w_streaming;
    logic                  w_boundary;
    logic                  w_busy;
    logic                  w_accept;
    logic                  w_req_seen;
    logic                  w_req_bad;
    logic                  w_req_take;
    logic                  w_guard_done;
    logic [CNT_W-1:0]      w_frame_bytes;
    cfg_t                  w_cfg_in;

    sync_ff #(
        .RESET_VAL (1'b0)
    ) u_streaming_sync (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .d_i       (streaming_i),
        .q_o       (w_streaming)
    );

    assign w_cfg_in.sample_rate = cfg_sample_rate_i;
    assign w_cfg_in.bit_depth   = cfg_bit_depth_i;
    assign w_cfg_in.channels    = cfg_channels_i;

    assign w_frame_bytes = frame_bytes(r_cfg.bit_depth, r_cfg.channels);
    assign w_boundary    = (r_cnt == '0);
    assign w_busy        = r_pending | (r_state != ST_RUN);
    assign w_guard_done  = (r_guard == GUARD_W'(GUARD_LIMIT));

`ifdef CFG_VALIDATE_EN
    assign w_req_bad = (cfg_bit_depth_i == BIT_DEPTH_32) || (cfg_bit_depth_i == BIT_DEPTH_DOP);
`else
    assign w_req_bad = 1'b0;
`endif

    assign w_req_seen = cfg_req_i & ~w_busy;
    assign w_req_take = w_req_seen & ~w_req_bad;

    // Ready is combinational so a full FIFO blocks the handshake in the same cycle.
    assign s_ready_o = (r_state == ST_RUN) & ~wr_afull_i & ~wr_full_i & ~(r_pending & w_boundary);
    assign w_accept  = s_valid_i & s_ready_o;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state           <= ST_SETTLE;
            r_settle          <= SETTLE_W'(SETTLE_CLOCKS - 1);
            r_cnt             <= '0;
            r_pending         <= 1'b0;
            r_req             <= '0;
            r_cfg.sample_rate <= '0;
            r_cfg.bit_depth   <= BIT_DEPTH_16;
            r_cfg.channels    <= CHANNELS_STEREO;
            r_guard           <= '0;
            r_wr_en           <= 1'b0;
            r_wr_data         <= '0;
            r_ack             <= 1'b0;
            r_err             <= 1'b0;
        end else begin
            r_wr_en <= w_accept;
            r_ack   <= 1'b0;
            r_err   <= w_req_seen & w_req_bad;
            if (w_accept) begin
                r_wr_data <= s_data_i;
                r_cnt     <= (r_cnt == w_frame_bytes - CNT_W'(1)) ? '0 : r_cnt + CNT_W'(1);
            end

            case (r_state)
                ST_RUN: begin
                    if (w_req_take) begin
                        r_req     <= w_cfg_in;
                        r_pending <= 1'b1;
                    end
                    // A byte taken on the boundary starts a new frame, so the stop waits for its end.
                    if ((r_pending | w_req_take) && w_boundary && !w_accept) begin
                        r_state <= ST_DRAIN;
                        r_guard <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (r_wr_en) begin
                        r_guard <= '0;
                    end else if (!w_guard_done) begin
                        r_guard <= r_guard + GUARD_W'(1);
                    end
                    if (!r_wr_en && w_guard_done && !w_streaming) begin
                        r_state   <= ST_APPLY;
                        r_cfg     <= r_req;
                        r_ack     <= 1'b1;
                        r_pending <= 1'b0;
                        r_cnt     <= '0;
                    end
                end
                ST_APPLY: begin
                    r_state  <= ST_SETTLE;
                    r_settle <= SETTLE_W'(SETTLE_CLOCKS - 1);
                end
                ST_SETTLE: begin
                    if (r_settle == '0) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_settle <= r_settle - SETTLE_W'(1);
                    end
                end
                default: r_state <= ST_SETTLE;
            endcase
        end
    end

    assign busy_o        = w_busy;
    assign cfg_ack_o     = r_ack;
    assign cfg_err_o     = r_err;
    assign wr_en_o       = r_wr_en;
    assign wr_data_o     = r_wr_data;
    assign sample_rate_o = r_cfg.sample_rate;
    assign bit_depth_o   = r_cfg.bit_depth;
    assign channels_o    = r_cfg.channels;

endmodule

// File: tb/tb_tx_stream_ctrl.sv
// Directed bench for tx_stream_ctrl with a byte scoreboard on the FIFO write port.
module tb_tx_stream_ctrl;

    logic       clk = 1'b0;
    logic       reset_n_i;
    logic       cfg_req_i;
    logic [2:0] cfg_sample_rate_i;
    logic [1:0] cfg_bit_depth_i;
    logic       cfg_channels_i;
    logic       cfg_ack_o;
    logic       cfg_err_o;
    logic       busy_o;
    logic [7:0] s_data_i;
    logic       s_valid_i;
    logic       s_ready_o;
    logic       wr_en_o;
    logic [7:0] wr_data_o;
    logic       wr_afull_i;
    logic       wr_full_i;
    logic       streaming_i;
    logic [2:0] sample_rate_o;
    logic [1:0] bit_depth_o;
    logic       channels_o;

    int checks = 0;
    int errors = 0;
    int n_sent = 0;
    int n_wr   = 0;
    logic       mon_on = 1'b0;
    logic       exp_wr = 1'b0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    tx_stream_ctrl dut (
        .clk_i             (clk),
        .reset_n_i         (reset_n_i),
        .cfg_req_i         (cfg_req_i),
        .cfg_sample_rate_i (cfg_sample_rate_i),
        .cfg_bit_depth_i   (cfg_bit_depth_i),
        .cfg_channels_i    (cfg_channels_i),
        .cfg_ack_o         (cfg_ack_o),
        .cfg_err_o         (cfg_err_o),
        .busy_o            (busy_o),
        .s_data_i          (s_data_i),
        .s_valid_i         (s_valid_i),
        .s_ready_o         (s_ready_o),
        .wr_en_o           (wr_en_o),
        .wr_data_o         (wr_data_o),
        .wr_afull_i        (wr_afull_i),
        .wr_full_i         (wr_full_i),
        .streaming_i       (streaming_i),
        .sample_rate_o     (sample_rate_o),
        .bit_depth_o       (bit_depth_o),
        .channels_o        (channels_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: each accepted byte must appear on the write port exactly one cycle later.
    always @(negedge clk) begin
        if (mon_on) begin
            chk("wr_en_latency", 32'(wr_en_o), 32'(exp_wr));
            if (wr_en_o) begin
                n_wr++;
                if (exp_q.size() == 0) chk("wr_unexpected", 32'(1), 32'(0));
                else chk("wr_data", 32'(wr_data_o), 32'(exp_q.pop_front()));
            end
            if (wr_full_i) chk("ready_while_full", 32'(s_ready_o), 32'(0));
            exp_wr = s_valid_i & s_ready_o;
            if (exp_wr) exp_q.push_back(s_data_i);
        end
    end

    task automatic send_byte(input logic [7:0] v);
        logic acc;
        int   n;
        s_valid_i = 1'b1;
        s_data_i  = v;
        n = 0;
        do begin
            @(negedge clk);
            acc = s_ready_o;
            tick();
            n++;
        end while (!acc && n < 300);
        if (!acc) chk("send_timeout", 32'(0), 32'(1));
        else n_sent++;
        s_valid_i = 1'b0;
    endtask

    task automatic send_run(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) send_byte(8'(first + 8'(i)));
    endtask

    task automatic req(input logic [2:0] sr, input logic [1:0] bd, input logic ch);
        cfg_sample_rate_i = sr;
        cfg_bit_depth_i   = bd;
        cfg_channels_i    = ch;
        cfg_req_i         = 1'b1;
        tick();
        cfg_req_i = 1'b0;
    endtask

    task automatic count_to_ready(input string tag, input int exp_edges);
        int n;
        n = 0;
        while (!s_ready_o && n < 300) begin
            tick();
            n++;
        end
        chk(tag, 32'(n), 32'(exp_edges));
    endtask

    task automatic ack_after_fall(input string tag);
        streaming_i = 1'b0;
        tick();
        chk({tag, "_early1"}, 32'(cfg_ack_o), 32'(0));
        tick();
        chk({tag, "_early2"}, 32'(cfg_ack_o), 32'(0));
        tick();
        chk({tag, "_ack"}, 32'(cfg_ack_o), 32'(1));
        tick();
        chk({tag, "_ack_pulse"}, 32'(cfg_ack_o), 32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        reset_n_i = 1'b1;
        cfg_req_i = 1'b0;
        cfg_sample_rate_i = '0;
        cfg_bit_depth_i = '0;
        cfg_channels_i = 1'b0;
        s_data_i = '0;
        s_valid_i = 1'b0;
        wr_afull_i = 1'b0;
        wr_full_i = 1'b0;
        streaming_i = 1'b0;
        #2 reset_n_i = 1'b0;
        #20;
        chk("rst_sample_rate", 32'(sample_rate_o), 32'(0));
        chk("rst_bit_depth", 32'(bit_depth_o), 32'(2'b00));
        chk("rst_channels", 32'(channels_o), 32'(1));
        chk("rst_ready", 32'(s_ready_o), 32'(0));
        chk("rst_wr_en", 32'(wr_en_o), 32'(0));
        chk("rst_wr_data", 32'(wr_data_o), 32'(0));
        chk("rst_ack", 32'(cfg_ack_o), 32'(0));
        chk("rst_err", 32'(cfg_err_o), 32'(0));

        // Release, settle hold-off, then 12 bytes in order.
        @(negedge clk);
        reset_n_i = 1'b1;
        mon_on = 1'b1;
        count_to_ready("reset_settle_edges", 64);
        send_run(8'h01, 12);
        repeat (3) tick();
        chk("t1_writes", 32'(n_wr), 32'(12));

        // Mid-frame request: finish the 4-byte frame, then hold until the transmitter stops.
        send_run(8'h10, 2);
        streaming_i = 1'b1;
        req(3'd2, 2'b01, 1'b1);
        chk("t2_busy", 32'(busy_o), 32'(1));
        send_run(8'h12, 2);
        s_valid_i = 1'b1;
        s_data_i = 8'hEE;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_ready_low", 32'(s_ready_o), 32'(0));
        end
        tick();
        s_valid_i = 1'b0;
        repeat (30) tick();
        chk("t2_no_ack_streaming", 32'(cfg_ack_o), 32'(0));
        ack_after_fall("t2");
        chk("t2_bit_depth", 32'(bit_depth_o), 32'(2'b01));
        chk("t2_sample_rate", 32'(sample_rate_o), 32'(2));
        chk("t2_channels", 32'(channels_o), 32'(1));
        count_to_ready("t2_settle_edges", 64);

        // Almost-full back-pressure, then a full 24-bit stereo frame.
        wr_afull_i = 1'b1;
        s_valid_i = 1'b1;
        s_data_i = 8'hAA;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t3_ready_afull", 32'(s_ready_o), 32'(0));
            tick();
        end
        wr_afull_i = 1'b0;
        wr_full_i = 1'b1;
        @(negedge clk);
        chk("t3_ready_full", 32'(s_ready_o), 32'(0));
        tick();
        wr_full_i = 1'b0;
        s_valid_i = 1'b0;
        send_run(8'h20, 6);

        // Boundary request with the transmitter busy; a second request while busy is dropped.
        streaming_i = 1'b1;
        req(3'd5, 2'b00, 1'b0);
        chk("t4_busy", 32'(busy_o), 32'(1));
        acks = 0;
        for (int i = 0; i < 50; i++) begin
            if (i == 10) begin
                req(3'd7, 2'b01, 1'b1);
                chk("t5_err_ignored", 32'(cfg_err_o), 32'(0));
            end else begin
                tick();
            end
            if (cfg_ack_o) acks++;
        end
        chk("t4_no_ack_streaming", 32'(acks), 32'(0));
        ack_after_fall("t4");
        chk("t5_sample_rate", 32'(sample_rate_o), 32'(5));
        chk("t5_bit_depth", 32'(bit_depth_o), 32'(2'b00));
        chk("t5_channels", 32'(channels_o), 32'(0));
        count_to_ready("t4_settle_edges", 64);
        chk("t5_busy_clear", 32'(busy_o), 32'(0));

        // Mono 16-bit frames are 2 bytes.
        send_run(8'h40, 4);
        repeat (5) tick();

`ifdef CFG_VALIDATE_EN
        req(3'd3, 2'b11, 1'b1);
        chk("t6_err_pulse", 32'(cfg_err_o), 32'(1));
        chk("t6_busy", 32'(busy_o), 32'(0));
        tick();
        chk("t6_err_clear", 32'(cfg_err_o), 32'(0));
        chk("t6_bit_depth_kept", 32'(bit_depth_o), 32'(2'b00));
        send_run(8'h50, 2);
        repeat (5) tick();
        req(3'd1, 2'b01, 1'b1);
`else
        req(3'd1, 2'b10, 1'b1);
        chk("t6_err_tied", 32'(cfg_err_o), 32'(0));
`endif
        // Minimum request-to-ack latency: guard plus synchronizer plus apply.
        for (int i = 2; i < 20; i++) begin
            tick();
            if (cfg_ack_o) chk("t7_early_ack", 32'(i), 32'(20));
        end
        tick();
        chk("t7_min_latency_ack", 32'(cfg_ack_o), 32'(1));
`ifdef CFG_VALIDATE_EN
        chk("t7_bit_depth", 32'(bit_depth_o), 32'(2'b01));
`else
        chk("t7_bit_depth", 32'(bit_depth_o), 32'(2'b10));
`endif
        chk("t7_sample_rate", 32'(sample_rate_o), 32'(1));

        repeat (3) tick();
        chk("final_writes", 32'(n_wr), 32'(n_sent));
        chk("final_queue_empty", 32'(exp_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
